sdram_arb: RTL and testbench



---
 rtl/vfd_pkg.sv | 6 +
 rtl/sdram_wdog.sv | 15 +
 rtl/sdram_arb.sv | 92 +++++++++
 tb/tb_sdram_arb.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfd_pkg.sv
// vfd_pkg: shared arbiter state type and artwork address constants
package vfd_pkg;
  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} arb_state_t;
  localparam int ADDR_W = 25;
  localparam int MASK_BASE = 640 * 480;
endpackage

// File: rtl/sdram_wdog.sv
// sdram_wdog: 8-bit clear/enable counter that expires after TIMEOUT enabled cycles
module sdram_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!reset_n || clr) ? 8'd0 : en ? cnt + 8'd1 : cnt;
  assign expired = en & (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/sdram_arb.sv
// sdram_arb: shares one SDRAM port between loader writes and compositor reads
module sdram_arb #(
  parameter int ADDR_W = vfd_pkg::ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_busy,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_wait,
  input  logic              cp_rd,
  input  logic [ADDR_W-1:0] cp_addr,
  output logic [7:0]        cp_data,
  output logic              cp_rdy,
  output logic              sd_req,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_din,
  input  logic              sd_ack,
  input  logic [7:0]        sd_dout,
  output logic              art_valid,
  output logic              err
);
  import vfd_pkg::*;
  arb_state_t state, state_n;
  logic buf_full, served, busy_q, wrote, armed, expired;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0] buf_data;
  logic idle, pend, done, accept, wr_go, rise, fall, set_valid;
  assign idle = state == IDLE;
  assign pend = cp_rd & ~served;
  assign done = ~idle & (sd_ack | expired);
  assign accept = ld_wr & ~buf_full;
  assign wr_go = buf_full | accept;
  assign rise = ld_busy & ~busy_q;
  assign fall = ~ld_busy & busy_q;
  assign set_valid = (armed | (fall & wrote)) & ~buf_full & ~ld_wr & idle;
  assign ld_wait = buf_full;
  assign cp_rdy = art_valid & ~pend;
  sdram_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .reset_n(reset_n),
    .clr(idle),
    .en(~idle),
    .expired(expired)
  );
  always_comb
    state_n = ~idle ? (done ? IDLE : state) : wr_go ? WR_WAIT : (pend & art_valid) ? RD_WAIT : IDLE;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      buf_full <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      served <= 1'b0;
      busy_q <= 1'b0;
      wrote <= 1'b0;
      armed <= 1'b0;
      sd_req <= 1'b0;
      sd_we <= 1'b0;
      sd_addr <= '0;
      sd_din <= '0;
      cp_data <= '0;
      art_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        buf_full <= 1'b1;
        buf_addr <= ld_addr;
        buf_data <= ld_data;
      end else if (done && state == WR_WAIT)
        buf_full <= 1'b0;
      served <= ~cp_rd ? 1'b0 : (done && state == RD_WAIT) ? 1'b1 : served;
      if (done && state == RD_WAIT)
        cp_data <= sd_ack ? sd_dout : 8'h00;
      if (idle && state_n != IDLE) begin
        sd_req <= 1'b1;
        sd_we <= state_n == WR_WAIT;
        sd_addr <= state_n == RD_WAIT ? cp_addr : buf_full ? buf_addr : ld_addr;
        sd_din <= buf_full ? buf_data : ld_data;
      end else if (done)
        sd_req <= 1'b0;
      busy_q <= ld_busy;
      wrote <= rise ? accept : wrote | (accept & ld_busy);
      armed <= (rise | set_valid) ? 1'b0 : fall ? wrote : armed;
      art_valid <= rise ? 1'b0 : set_valid ? 1'b1 : art_valid;
      err <= err | (ld_wr & buf_full) | (expired & ~sd_ack);
    end
endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: randomized self-checking bench for sdram_arb with an SDRAM responder
module tb_sdram_arb;
  import vfd_pkg::*;
  localparam int AW = 25;
  localparam int TO = 4;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [7:0] data;} txn_t;
  logic clk = 1'b0;
  logic reset_n, ld_busy, ld_wr, ld_wait, cp_rd, cp_rdy, sd_req, sd_we, sd_ack, art_valid, err;
  logic [AW-1:0] ld_addr, cp_addr, sd_addr;
  logic [7:0] ld_data, cp_data, sd_din, sd_dout;
  int checks = 0, errors = 0;
  int ack_dly = 2;
  bit ack_en = 1'b1;
  logic [7:0] sd_mem [logic [AW-1:0]];
  logic [7:0] ref_mem [logic [AW-1:0]];
  txn_t act_q[$], exp_q[$];
  always #5 clk = ~clk;
  sdram_arb #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_busy(ld_busy), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_wait(ld_wait),
    .cp_rd(cp_rd), .cp_addr(cp_addr), .cp_data(cp_data), .cp_rdy(cp_rdy),
    .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din),
    .sd_ack(sd_ack), .sd_dout(sd_dout), .art_valid(art_valid), .err(err)
  );
  function automatic logic [7:0] dflt(logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] ref_val(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  initial begin
    int w;
    logic [7:0] rd;
    w = 0;
    sd_ack = 1'b0;
    sd_dout = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (sd_ack) begin
        sd_ack = 1'b0;
        w = 0;
      end else if (sd_req && reset_n) begin
        if (ack_en && w >= ack_dly) begin
          rd = sd_mem.exists(sd_addr) ? sd_mem[sd_addr] : dflt(sd_addr);
          sd_ack = 1'b1;
          sd_dout = sd_we ? 8'h00 : rd;
          if (sd_we) sd_mem[sd_addr] = sd_din;
          act_q.push_back(txn_t'({sd_we, sd_addr, sd_we ? sd_din : rd}));
        end
        w++;
      end else
        w = 0;
    end
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    cp_rd = 1'b1;
    cp_addr = 25'h123;
    tick(3);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (sd_req !== 1'b0) begin errors++; $display("FAIL reset_sd_req cycle %0d: got %b want 0", i, sd_req); end
    end
    checks++;
    if ({sd_we, art_valid, err, ld_wait, cp_rdy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got we/av/err/wait/rdy=%b want 00000", {sd_we, art_valid, err, ld_wait, cp_rdy});
    end
    checks++;
    if (sd_addr !== '0 || sd_din !== 8'h00 || cp_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got addr=%h din=%h cp_data=%h want 0", sd_addr, sd_din, cp_data);
    end
    cp_rd = 1'b0;
    tick;
  endtask
  task automatic test_download;
    int n;
    ack_dly = 2;
    ld_busy = 1'b1;
    tick;
    ld_wr = 1'b1;
    ld_addr = 25'h4B001;
    ld_data = 8'h5A;
    ref_mem[25'h4B001] = 8'h5A;
    tick;
    ld_wr = 1'b0;
    checks++;
    if (ld_wait !== 1'b1) begin errors++; $display("FAIL dl_ld_wait: got %b want 1", ld_wait); end
    n = 0;
    while (!sd_req && n < 10) begin tick; n++; end
    checks++;
    if (sd_req !== 1'b1 || sd_we !== 1'b1 || sd_addr !== 25'h4B001 || sd_din !== 8'h5A) begin
      errors++; $display("FAIL dl_write: got req=%b we=%b addr=%h din=%h want 1 1 4b001 5a", sd_req, sd_we, sd_addr, sd_din);
    end
    n = 0;
    while (sd_req && n < 10) begin tick; n++; end
    checks++;
    if (sd_req !== 1'b0 || ld_wait !== 1'b0 || art_valid !== 1'b0) begin
      errors++; $display("FAIL dl_done: got req=%b wait=%b av=%b want 0 0 0", sd_req, ld_wait, art_valid);
    end
    ld_busy = 1'b0;
    tick;
    checks++;
    if (art_valid !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL dl_art_valid: got av=%b err=%b want 1 0", art_valid, err);
    end
    checks++;
    if (act_q.size() != 1 || act_q[0] !== txn_t'({1'b1, 25'h4B001, 8'h5A})) begin
      errors++; $display("FAIL dl_txn: got %0d transactions want 1 write 4b001/5a", act_q.size());
    end
    act_q.delete();
  endtask
  task automatic test_read;
    int n, low;
    ack_dly = 3;
    sd_mem[25'h10] = 8'hC3;
    ref_mem[25'h10] = 8'hC3;
    cp_addr = 25'h10;
    cp_rd = 1'b1;
    #1;
    checks++;
    if (cp_rdy !== 1'b0) begin errors++; $display("FAIL rd_rdy_drop: got %b want 0", cp_rdy); end
    tick;
    checks++;
    if (sd_req !== 1'b1 || sd_we !== 1'b0 || sd_addr !== 25'h10) begin
      errors++; $display("FAIL rd_issue: got req=%b we=%b addr=%h want 1 0 00010", sd_req, sd_we, sd_addr);
    end
    low = 1;
    while (!cp_rdy && low < 20) begin tick; low++; end
    checks++;
    if (low != ack_dly + 2) begin errors++; $display("FAIL rd_latency: got %0d low cycles want %0d", low, ack_dly + 2); end
    checks++;
    if (cp_rdy !== 1'b1 || cp_data !== 8'hC3) begin
      errors++; $display("FAIL rd_data: got rdy=%b data=%h want 1 c3", cp_rdy, cp_data);
    end
    cp_rd = 1'b0;
    tick;
    cp_addr = 25'h11;
    cp_rd = 1'b1;
    tick;
    checks++;
    if (sd_req !== 1'b1 || sd_addr !== 25'h11) begin
      errors++; $display("FAIL rd_second_issue: got req=%b addr=%h want 1 00011", sd_req, sd_addr);
    end
    n = 0;
    while (!cp_rdy && n < 20) begin tick; n++; end
    checks++;
    if (cp_rdy !== 1'b1 || cp_data !== ref_val(25'h11)) begin
      errors++; $display("FAIL rd_second_data: got rdy=%b data=%h want 1 %h", cp_rdy, cp_data, ref_val(25'h11));
    end
    cp_rd = 1'b0;
    tick;
    act_q.delete();
  endtask
  task automatic test_collision;
    int n;
    ack_dly = 2;
    ld_wr = 1'b1;
    ld_addr = 25'h20;
    ld_data = 8'h77;
    ref_mem[25'h20] = 8'h77;
    cp_addr = 25'h20;
    cp_rd = 1'b1;
    tick;
    ld_wr = 1'b0;
    checks++;
    if (sd_req !== 1'b1 || sd_we !== 1'b1 || sd_addr !== 25'h20) begin
      errors++; $display("FAIL col_write_first: got req=%b we=%b addr=%h want 1 1 00020", sd_req, sd_we, sd_addr);
    end
    n = 0;
    while (!sd_ack && n < 10) begin tick; n++; end
    tick;
    checks++;
    if (sd_req !== 1'b0) begin errors++; $display("FAIL col_gap: got req=%b want 0", sd_req); end
    tick;
    checks++;
    if (sd_req !== 1'b1 || sd_we !== 1'b0 || sd_addr !== 25'h20) begin
      errors++; $display("FAIL col_read_next: got req=%b we=%b addr=%h want 1 0 00020", sd_req, sd_we, sd_addr);
    end
    n = 0;
    while (!cp_rdy && n < 20) begin tick; n++; end
    checks++;
    if (cp_data !== 8'h77) begin errors++; $display("FAIL col_read_data: got %h want 77", cp_data); end
    cp_rd = 1'b0;
    tick;
    act_q.delete();
  endtask
  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int op, n;
      logic [AW-1:0] wa, ra;
      logic [7:0] wd;
      op = $urandom_range(0, 2);
      ack_dly = $urandom_range(1, 3);
      wa = AW'(($urandom_range(0, 1) != 0 ? MASK_BASE : 0) + $urandom_range(0, 15));
      ra = AW'(($urandom_range(0, 1) != 0 ? MASK_BASE : 0) + $urandom_range(0, 15));
      if (op == 2 && $urandom_range(0, 1) != 0) ra = wa;
      wd = 8'($urandom);
      if (op != 1) begin
        ld_wr = 1'b1;
        ld_addr = wa;
        ld_data = wd;
        ref_mem[wa] = wd;
        exp_q.push_back(txn_t'({1'b1, wa, wd}));
      end
      if (op != 0) begin
        cp_rd = 1'b1;
        cp_addr = ra;
        exp_q.push_back(txn_t'({1'b0, ra, ref_val(ra)}));
      end
      tick;
      ld_wr = 1'b0;
      n = 0;
      while ((sd_req || ld_wait || (cp_rd && !cp_rdy)) && n < 30) begin tick; n++; end
      checks++;
      if (n >= 30) begin errors++; $display("FAIL rnd_hang iter %0d: still busy after %0d cycles want idle", i, n); end
      if (op != 0) begin
        checks++;
        if (cp_data !== ref_val(ra)) begin
          errors++; $display("FAIL rnd_read iter %0d addr %h: got %h want %h", i, ra, cp_data, ref_val(ra));
        end
      end
      cp_rd = 1'b0;
      tick($urandom_range(1, 2));
      checks++;
      if (act_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd_txn_count iter %0d: got %0d want %0d", i, act_q.size(), exp_q.size());
      end else
        for (int j = 0; j < exp_q.size(); j++)
          if (act_q[j] !== exp_q[j]) begin
            errors++; $display("FAIL rnd_txn iter %0d #%0d: got %h want %h", i, j, act_q[j], exp_q[j]);
          end
      act_q.delete();
      exp_q.delete();
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rnd_err: got %b want 0", err); end
  endtask
  task automatic test_timeout;
    int n;
    ack_en = 1'b0;
    cp_addr = 25'h33;
    cp_rd = 1'b1;
    tick;
    checks++;
    if (sd_req !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL to_issue: got req=%b err=%b want 1 0", sd_req, err); end
    n = 0;
    while (sd_req && n < 20) begin tick; n++; end
    checks++;
    if (n != TO) begin errors++; $display("FAIL to_req_width: got %0d cycles want %0d", n, TO); end
    checks++;
    if (err !== 1'b1 || cp_data !== 8'h00 || cp_rdy !== 1'b1) begin
      errors++; $display("FAIL to_result: got err=%b data=%h rdy=%b want 1 00 1", err, cp_data, cp_rdy);
    end
    ack_en = 1'b1;
    cp_rd = 1'b0;
    tick(2);
    checks++;
    if (act_q.size() != 0 || sd_req !== 1'b0) begin
      errors++; $display("FAIL to_quiet: got %0d txns req=%b want 0 0", act_q.size(), sd_req);
    end
    act_q.delete();
  endtask
  task automatic test_overflow;
    int n;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick;
    checks++;
    if (err !== 1'b0 || art_valid !== 1'b0) begin errors++; $display("FAIL ov_reset: got err=%b av=%b want 0 0", err, art_valid); end
    act_q.delete();
    ack_dly = 3;
    ld_busy = 1'b1;
    tick;
    ld_wr = 1'b1;
    ld_addr = 25'h40;
    ld_data = 8'h11;
    tick;
    checks++;
    if (ld_wait !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ov_first: got wait=%b err=%b want 1 0", ld_wait, err); end
    ld_addr = 25'h41;
    ld_data = 8'h22;
    tick;
    ld_wr = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ov_err: got %b want 1", err); end
    n = 0;
    while ((sd_req || ld_wait) && n < 20) begin tick; n++; end
    tick(3);
    checks++;
    if (act_q.size() != 1 || act_q[0] !== txn_t'({1'b1, 25'h40, 8'h11})) begin
      errors++; $display("FAIL ov_txn: got %0d txns want 1 write 00040/11", act_q.size());
    end
    ld_busy = 1'b0;
    tick;
    checks++;
    if (art_valid !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL ov_art_valid: got av=%b err=%b want 1 1", art_valid, err); end
    ld_busy = 1'b1;
    tick;
    checks++;
    if (art_valid !== 1'b0) begin errors++; $display("FAIL empty_dl_clear: got %b want 0", art_valid); end
    ld_busy = 1'b0;
    tick(3);
    checks++;
    if (art_valid !== 1'b0) begin errors++; $display("FAIL empty_dl_stays: got %b want 0", art_valid); end
  endtask
  initial begin
    reset_n = 1'b0;
    ld_busy = 1'b0;
    ld_wr = 1'b0;
    ld_addr = '0;
    ld_data = 8'h00;
    cp_rd = 1'b0;
    cp_addr = '0;
    test_reset;
    test_download;
    test_read;
    test_collision;
    test_random;
    test_timeout;
    test_overflow;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
